nand4_response_checker: RTL and testbench
=========================================

# nand4_response_checker

Clocked response checker for the 4-input NAND gate. It samples each applied input vector together with the gate's output, compares the output against the expected NAND value, and tracks which of the 2^N_IN input combinations have been exercised. It counts mismatches, latches the first failing vector, and reports a final pass/fail verdict. It sits at the receiving end of the exhaustive-stimulus path: the stimulus source drives the gate inputs, and this block consumes what comes back.

## Interface
- N_IN, 4, number of gate inputs; the coverage space is 2^N_IN vectors.
- CNT_W, 8, width of the sample and error counters.
- MAX_SAMPLES, 64, timeout: number of accepted samples after which the run ends even if coverage is incomplete. Legal range 1 to 2^CNT_W-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle pulse that begins a run and clears all results.
- sample_valid  input  1  when high, vec/dut_out are a settled sample to be checked this cycle.
- vec  input  N_IN  input vector applied to the gate.
- dut_out  input  1  gate output observed for vec.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid only when done: err_cnt==0 and coverage complete.
- err_cnt  output  CNT_W  mismatch count, saturating.
- sample_cnt  output  CNT_W  accepted samples this run.
- cov_mask  output  2^N_IN  bit k set once vec==k has been sampled.
- first_err_valid  output  1  set on the first mismatch of a run.
- first_err_vec  output  N_IN  vec of the first mismatch.

## Operation
- Expected value: exp = ~&vec.
- A sample is a mismatch when dut_out != exp. X or Z on dut_out counts as a mismatch: compare with !==, and in RTL use a case-equality-safe compare.
- FSM states: IDLE, RUN, DONE.
- IDLE: sample_valid is ignored. start moves to RUN and clears every result register.
- RUN, on an accepted sample (sample_valid=1):
  - sample_cnt increments.
  - cov_mask[vec] is set.
  - On mismatch, err_cnt increments, saturating at 2^CNT_W-1.
  - On the first mismatch of the run only, first_err_vec captures vec and first_err_valid goes high.
- RUN → DONE when the registered cov_mask is all ones, or when sample_cnt == MAX_SAMPLES.
- DONE: results hold and sample_valid is ignored. start clears the results and re-enters RUN.
- start while in RUN: the run restarts. Results clear, and any sample_valid in that same cycle is discarded.
- Duplicate vectors are legal. They are counted and checked, and the coverage bit simply stays set.
- pass = done & (err_cnt==0) & (&cov_mask). A timeout with incomplete coverage gives pass=0 even when err_cnt==0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, sample_cnt=0, cov_mask=0, first_err_valid=0, first_err_vec=0.
- Asserting rst_n low mid-run forces all of the above immediately, with no dependence on clk.
- start sampled high at edge E:
  - busy=1 and results are zero after E.
  - The first sample that can be accepted is at edge E+1.
- Sample accepted at edge N: counters, cov_mask and first_err_* are updated after N (1-cycle latency).
- The completion condition is evaluated on registered values, so done=1 and busy=0 after edge N+1, where N is the completing sample. A sample_valid at N+1 is still accepted while the state is RUN.
- pass is combinational from registered state and is meaningful only while done=1.
- sample_valid may be held high for consecutive cycles; one sample is accepted per cycle.

## Test plan
- Correct NAND, exhaustive: start, then vec=0..15 with correct dut_out, one per cycle → done 2 cycles after the last sample, cov_mask=16'hFFFF, err_cnt=0, sample_cnt=16, pass=1.
- Stuck-at-1 output: dut_out forced to 1, sweep 0..15 → err_cnt=1, first_err_vec=4'hF, first_err_valid=1, pass=0.
- Incomplete coverage with timeout: repeat vec=3 with correct output for 64 samples → done at timeout, sample_cnt=64, cov_mask=16'h0008, err_cnt=0, pass=0.
- Error saturation with CNT_W=4 and MAX_SAMPLES=15:
  - Drive 15 mismatches on vec=0 → err_cnt=15.
  - Then restart with CNT_W=4, MAX_SAMPLES=15: 20 mismatches on vec=0 → run ends at 15 samples, err_cnt=15 with no wrap.
- X handling: dut_out=1'bx on vec=5 → err_cnt=1, first_err_vec=4'h5.
- Reset and restart:
  - Drop rst_n at sample 7 of a sweep → all outputs return to 0 immediately, state IDLE.
  - In a later sweep, start at sample 7 → results clear and the run resumes.
  - start asserted in DONE → new run with cleared results.

Source files
------------

// File: rtl/nand4_response_checker_if.sv
// Stimulus/response bundle between the exhaustive-stimulus source and the NAND4 response checker.
// The source side is master; the checker side is slave.
interface nand4_response_checker_if #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 8
);
  logic                    start;
  logic                    sample_valid;
  logic [N_IN-1:0]         vec;
  logic                    dut_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [CNT_W-1:0]        err_cnt;
  logic [CNT_W-1:0]        sample_cnt;
  logic [(1<<N_IN)-1:0]    cov_mask;
  logic                    first_err_valid;
  logic [N_IN-1:0]         first_err_vec;

  modport master (
    output start, sample_valid, vec, dut_out,
    input  busy, done, pass, err_cnt, sample_cnt, cov_mask, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, sample_valid, vec, dut_out,
    output busy, done, pass, err_cnt, sample_cnt, cov_mask, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/nand4_response_checker.sv
// Checks sampled NAND4 outputs against ~&vec, tracks vector coverage, counts mismatches
// and latches the first failing vector, then reports a pass/fail verdict.
module nand4_response_checker #(
  parameter int N_IN        = 4,
  parameter int CNT_W       = 8,
  parameter int MAX_SAMPLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  nand4_response_checker_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, samples ignored
  // RUN   | accepting and checking samples
  // DONE  | coverage complete or sample budget spent, results held
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int               N_VEC   = 1 << N_IN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_SAMPLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic [N_VEC-1:0] cov_mask;
  logic             first_err_valid;
  logic [N_IN-1:0]  first_err_vec;

  logic exp_out;
  logic mismatch;
  logic complete;

  assign exp_out  = ~&bus.vec;
  // X/Z on the observed output must register as a failure in simulation
  assign mismatch = (bus.dut_out !== exp_out);
  assign complete = (&cov_mask) || (sample_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      err_cnt         <= '0;
      sample_cnt      <= '0;
      cov_mask        <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      if (bus.start) begin
        state           <= RUN;
        err_cnt         <= '0;
        sample_cnt      <= '0;
        cov_mask        <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
      end else if (state == RUN) begin
        if (complete)
          state <= DONE;
        // a sample on the completing edge is still taken, so the sample count saturates too
        if (bus.sample_valid) begin
          if (sample_cnt != CNT_MAX)
            sample_cnt <= sample_cnt + 1'b1;
          cov_mask <= cov_mask | (N_VEC'(1) << bus.vec);
          if (mismatch) begin
            if (err_cnt != CNT_MAX)
              err_cnt <= err_cnt + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= bus.vec;
            end
          end
        end
      end
    end
  end

  assign bus.busy            = (state == RUN);
  assign bus.done            = (state == DONE);
  assign bus.pass            = (state == DONE) && (err_cnt == '0) && (&cov_mask);
  assign bus.err_cnt         = err_cnt;
  assign bus.sample_cnt      = sample_cnt;
  assign bus.cov_mask        = cov_mask;
  assign bus.first_err_valid = first_err_valid;
  assign bus.first_err_vec   = first_err_vec;
endmodule

// File: tb/tb_nand4_response_checker.sv
// Scoreboard bench for nand4_response_checker: a reference model pushes the expected
// result of each driven cycle, which is popped and compared after the clock edge.
module tb_nand4_response_checker;
  logic clk;
  logic rst_n;

  nand4_response_checker_if #(.N_IN(4), .CNT_W(8)) bus ();
  nand4_response_checker #(.N_IN(4), .CNT_W(8), .MAX_SAMPLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  nand4_response_checker_if #(.N_IN(4), .CNT_W(4)) bus_s ();
  nand4_response_checker #(.N_IN(4), .CNT_W(4), .MAX_SAMPLES(15)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int          st;
    int          err;
    int          cnt;
    logic [15:0] cov;
    logic        fe;
    logic [3:0]  fev;
  } exp_t;

  exp_t sb[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_state;
  int          m_err;
  int          m_cnt;
  logic [15:0] m_cov;
  logic        m_fe;
  logic [3:0]  m_fev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_clear();
    m_err = 0; m_cnt = 0; m_cov = '0; m_fe = 1'b0; m_fev = '0;
  endtask

  // One clock of stimulus on the main checker, with the model advanced for the same edge.
  task automatic step(input bit st, input bit vld, input logic [3:0] v, input logic o);
    exp_t e;
    exp_t g;
    bus.start = st; bus.sample_valid = vld; bus.vec = v; bus.dut_out = o;
    if (st) begin
      model_clear();
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_cov == 16'hFFFF || m_cnt == 64) m_state = M_DONE;
      if (vld) begin
        if (m_cnt < 255) m_cnt++;
        m_cov[v] = 1'b1;
        if (o !== ~&v) begin
          if (m_err < 255) m_err++;
          if (!m_fe) begin m_fe = 1'b1; m_fev = v; end
        end
      end
    end
    e.st = m_state; e.err = m_err; e.cnt = m_cnt; e.cov = m_cov; e.fe = m_fe; e.fev = m_fev;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    chk("busy", bus.busy, g.st == M_RUN);
    chk("done", bus.done, g.st == M_DONE);
    chk("err_cnt", bus.err_cnt, g.err);
    chk("sample_cnt", bus.sample_cnt, g.cnt);
    chk("cov_mask", bus.cov_mask, g.cov);
    chk("first_err_valid", bus.first_err_valid, g.fe);
    chk("first_err_vec", bus.first_err_vec, g.fev);
    if (g.st == M_DONE)
      chk("pass", bus.pass, (g.err == 0) && (g.cov == 16'hFFFF));
    bus.start = 1'b0; bus.sample_valid = 1'b0;
  endtask

  task automatic step_s(input bit st, input bit vld, input logic [3:0] v, input logic o);
    bus_s.start = st; bus_s.sample_valid = vld; bus_s.vec = v; bus_s.dut_out = o;
    @(posedge clk); #1;
    bus_s.start = 1'b0; bus_s.sample_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_err"}, bus.err_cnt, 0);
    chk({tag, "_cnt"}, bus.sample_cnt, 0);
    chk({tag, "_cov"}, bus.cov_mask, 0);
    chk({tag, "_fe"}, bus.first_err_valid, 0);
    chk({tag, "_fev"}, bus.first_err_vec, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sample_valid = 1'b0; bus.vec = '0; bus.dut_out = 1'b0;
    bus_s.start = 1'b0; bus_s.sample_valid = 1'b0; bus_s.vec = '0; bus_s.dut_out = 1'b0;
    m_state = M_IDLE;
    model_clear();
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // samples are ignored in IDLE
    step(0, 1, 4'd2, 1'b0);

    // exhaustive sweep with a correct gate
    step(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), ~&4'(i));
    step(0, 0, 4'd0, 1'b0);
    chk("exh_done", bus.done, 1);
    chk("exh_cov", bus.cov_mask, 16'hFFFF);
    chk("exh_cnt", bus.sample_cnt, 16);
    chk("exh_pass", bus.pass, 1);
    // results hold in DONE and further samples are ignored
    step(0, 1, 4'd1, 1'b0);

    // output stuck at 1: only vec=F fails
    step(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 1'b1);
    step(0, 0, 4'd0, 1'b0);
    chk("sa1_err", bus.err_cnt, 1);
    chk("sa1_fev", bus.first_err_vec, 4'hF);
    chk("sa1_fe", bus.first_err_valid, 1);
    chk("sa1_pass", bus.pass, 0);

    // output stuck at 0: first failure must stay at vec 0
    step(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 1'b0);
    step(0, 0, 4'd0, 1'b0);
    chk("sa0_err", bus.err_cnt, 15);
    chk("sa0_fev", bus.first_err_vec, 4'h0);

    // timeout with incomplete coverage
    step(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 64; i++) step(0, 1, 4'd3, 1'b1);
    step(0, 0, 4'd0, 1'b0);
    chk("tmo_done", bus.done, 1);
    chk("tmo_cnt", bus.sample_cnt, 64);
    chk("tmo_cov", bus.cov_mask, 16'h0008);
    chk("tmo_err", bus.err_cnt, 0);
    chk("tmo_pass", bus.pass, 0);

    // unknown output value counts as a mismatch
    step(1, 0, 4'd0, 1'b0);
    step(0, 1, 4'd5, 1'bx);
    chk("x_err", bus.err_cnt, 1);
    chk("x_fev", bus.first_err_vec, 4'h5);

    // start mid-run restarts and discards the coincident sample
    step(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(0, 1, 4'(i), (i == 2) ? 1'b0 : ~&4'(i));
    step(1, 1, 4'd7, 1'b0);
    chk("rst_run_cnt", bus.sample_cnt, 0);
    chk("rst_run_err", bus.err_cnt, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), ~&4'(i));
    step(0, 0, 4'd0, 1'b0);
    chk("rst_run_pass", bus.pass, 1);

    // asynchronous reset in the middle of a sweep
    step(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(0, 1, 4'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    m_state = M_IDLE;
    model_clear();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 4'd0, 1'b0);
    for (int i = 15; i >= 0; i--) step(0, 1, 4'(i), ~&4'(i));
    step(0, 0, 4'd0, 1'b0);
    chk("after_rst_pass", bus.pass, 1);

    // 4-bit counters, 15-sample budget: error count must saturate, not wrap
    step_s(1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 15; i++) step_s(0, 1, 4'd0, 1'b0);
    chk("sat_err15", bus_s.err_cnt, 15);
    chk("sat_cnt15", bus_s.sample_cnt, 15);
    step_s(1, 0, 4'd0, 1'b0);
    chk("sat_restart_err", bus_s.err_cnt, 0);
    for (int i = 0; i < 20; i++) step_s(0, 1, 4'd0, 1'b0);
    chk("sat_done", bus_s.done, 1);
    chk("sat_err", bus_s.err_cnt, 15);
    chk("sat_cnt", bus_s.sample_cnt, 15);
    chk("sat_cov", bus_s.cov_mask, 16'h0001);
    chk("sat_pass", bus_s.pass, 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
